// File: rtl/ps2_pkg.sv
// Shared scan-code constants, button indices, event type and FSM states
// for the PS/2 set-2 keymap block.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ERR   = 8'hFC;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_FIRE1 = 8'h14;
    localparam logic [7:0] SC_FIRE2 = 8'h11;
    localparam logic [7:0] SC_START = 8'h5A;
    localparam logic [7:0] SC_COIN  = 8'h16;

    localparam logic [2:0] BTN_UP    = 3'd0;
    localparam logic [2:0] BTN_DOWN  = 3'd1;
    localparam logic [2:0] BTN_LEFT  = 3'd2;
    localparam logic [2:0] BTN_RIGHT = 3'd3;
    localparam logic [2:0] BTN_FIRE1 = 3'd4;
    localparam logic [2:0] BTN_FIRE2 = 3'd5;
    localparam logic [2:0] BTN_START = 3'd6;
    localparam logic [2:0] BTN_COIN  = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_t;

    // Returns {hit, button index}; hit=0 for codes that drive no button.
    function automatic logic [3:0] key_map(input logic ext, input logic [7:0] code);
        logic [3:0] r;
        r = '0;
        if (ext) begin
            case (code)
                SC_UP:    r = {1'b1, BTN_UP};
                SC_DOWN:  r = {1'b1, BTN_DOWN};
                SC_LEFT:  r = {1'b1, BTN_LEFT};
                SC_RIGHT: r = {1'b1, BTN_RIGHT};
                default:  r = '0;
            endcase
        end else begin
            case (code)
                SC_FIRE1: r = {1'b1, BTN_FIRE1};
                SC_FIRE2: r = {1'b1, BTN_FIRE2};
                SC_START: r = {1'b1, BTN_START};
                SC_COIN:  r = {1'b1, BTN_COIN};
                default:  r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keymap_if.sv
// Event handshake between the keymap (master) and its consumer (slave).
interface ps2_keymap_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; head entry visible whenever not empty, zero otherwise.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ps2_evt_t din,
    input  logic     pop,
    output ps2_evt_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    ps2_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ps2_keymap.sv
// PS/2 set-2 prefix decoder, arcade button register and event queue.
// Optional: define PS2_REPEAT_FILTER_EN to drop typematic repeats of held mapped keys.
module ps2_keymap
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    code_in,
    input  logic          code_valid,
    output logic [7:0]    buttons,
    output logic          overflow,
    ps2_keymap_if.master  evt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t  state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        valid_q;
    logic        accept;
    logic [7:0]  btn_d;
    logic        emit, e_ext, e_brk;
    logic        push;
    logic [3:0]  map;
    ps2_evt_t    push_evt, head;
    logic        full, empty, pop;

    assign accept   = code_valid & ~valid_q;
    assign pop      = evt.evt_valid & evt.evt_ready;
    assign push_evt = '{ext: e_ext, brk: e_brk, code: code_in};

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        btn_d   = buttons;
        emit    = 1'b0;
        e_ext   = 1'b0;
        e_brk   = 1'b0;
        push    = 1'b0;
        map     = '0;
        if (accept) begin
            tcnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (code_in == SC_EXT)      state_d = ST_EXT;
                    else if (code_in == SC_BRK) state_d = ST_BRK;
                    else if (code_in == SC_BAT || code_in == SC_ERR ||
                             code_in == 8'h00  || code_in == 8'hFF)
                        btn_d = '0;
                    else emit = 1'b1;
                end
                ST_EXT: begin
                    if (code_in == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (code_in != SC_EXT) begin
                        emit    = 1'b1;
                        e_ext   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit    = 1'b1;
                    e_brk   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    emit    = 1'b1;
                    e_ext   = 1'b1;
                    e_brk   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix is abandoned silently.
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end

        if (emit) begin
            push = 1'b1;
            map  = key_map(e_ext, code_in);
            if (map[3]) begin
`ifdef PS2_REPEAT_FILTER_EN
                if (!e_brk && buttons[map[2:0]]) push = 1'b0;
`endif
                btn_d[map[2:0]] = ~e_brk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tcnt_q   <= '0;
            valid_q  <= 1'b0;
            buttons  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            valid_q  <= code_valid;
            buttons  <= btn_d;
            overflow <= push & full & ~pop;
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt.evt_valid = ~empty;
    assign evt.evt_code  = head.code;
    assign evt.evt_ext   = head.ext;
    assign evt.evt_break = head.brk;
endmodule

// File: doc/ps2_keymap.md
Name: ps2_keymap

Overview:
- Downstream of the PS/2 receiver; consumes its `code`/`valid` pair in the same 50 MHz domain.
- Decodes scan-code set 2 prefix sequences (E0 extended, F0 break) into key events.
- Keeps a live 8-bit arcade button vector for the game logic.
- Queues decoded events in a small show-ahead FIFO drained with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 100000, clk cycles a prefix state may wait for its next byte (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- code_in  in  8  byte from the PS/2 receiver.
- code_valid  in  1  receiver valid level. Stays high until the next frame starts, so it is edge-detected here.
- buttons  out  8  pressed state: [0] up, [1] down, [2] left, [3] right, [4] fire1, [5] fire2, [6] start, [7] coin.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts head entry this cycle.
- evt_code  out  8  head entry: final scan-code byte.
- evt_ext  out  1  head entry: E0 prefix was present.
- evt_break  out  1  head entry: release (F0 seen).
- overflow  out  1  one-cycle pulse when an event is dropped on a full FIFO.

Behaviour:
- Reset (rst low, async): buttons=0, FIFO empty, evt_valid=0, evt_code/evt_ext/evt_break=0, overflow=0, state=IDLE, timeout counter=0, valid-edge register=0.
- Byte acceptance:
  - accept = code_valid & ~valid_q, where valid_q is code_valid delayed one clk.
  - All state, button and FIFO updates occur at the same clk edge that samples accept=1 (1-cycle latency from the rising edge of code_valid).
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- Transitions on an accepted byte:
  - IDLE: E0 -> EXT; F0 -> BRK.
  - IDLE: AA, FC, 00 or FF -> buttons cleared to 0, no event, stay IDLE.
  - IDLE: any other byte -> make event (ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> make event (ext=1), then IDLE.
  - BRK: any byte -> break event (ext=0), then IDLE.
  - EXT_BRK: any byte -> break event (ext=1), then IDLE.
- Timeout:
  - The counter runs in any non-IDLE state and clears on every accepted byte and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE; no event is emitted.
- Button map (make sets the bit, break clears it):
  - E0 75 = up, E0 72 = down, E0 6B = left, E0 74 = right.
  - 14 = fire1, 11 = fire2, 5A = start, 16 = coin (all non-extended).
  - Other codes leave buttons unchanged but are still queued.
  - The button update is independent of FIFO space.
- FIFO:
  - Show-ahead; head entry is driven on evt_* whenever evt_valid=1.
  - A pop occurs when evt_valid & evt_ready. Head outputs hold stable while evt_valid=1 and evt_ready=0.
  - Push with FIFO full and no pop: event dropped, overflow=1 for that cycle, FIFO contents unchanged.
  - Push with FIFO full and a simultaneous pop: both happen, no overflow.
  - Push with FIFO empty: evt_valid rises the cycle after the push (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- Reset mid-sequence (e.g. after E0) discards the prefix and all queued events.

Optional Feature:
- PS2_REPEAT_FILTER_EN defined:
  - A make event for a mapped key whose button bit is already 1 is not queued; buttons stay unchanged. This suppresses typematic repeats.
  - Unmapped keys and all break events are queued as normal.
- Undefined: every make event is queued, including repeats.

Decomposition:
- ps2_pkg holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, SC_ERR=FC, and the eight mapped codes.
  - button index constants BTN_UP..BTN_COIN.
  - a 10-bit packed event typedef {ext, brk, code[7:0]}.
  - the FSM state enum.
- One sub-module: ps2_evt_fifo, a parameterised show-ahead FIFO over the event typedef with push/pop/full/empty. Decoder, FSM and button register stay in ps2_keymap.

Test Plan:
- Make/break: send 14 with evt_ready=1 -> buttons[4]=1, event {code=14, ext=0, brk=0}. Then send F0, 14 -> buttons[4]=0, event {14, 0, 1}. F0 itself queues nothing.
- Extended: send E0 75, then E0 F0 75 -> buttons[0] goes 1 then 0. Events {75, 1, 0} then {75, 1, 1}. Unmapped E0 1F queues {1F, 1, 0} and leaves buttons unchanged.
- Level valid: hold code_valid high 5000 cycles with code_in=5A -> exactly one event, buttons[6]=1.
- Backpressure/overflow: evt_ready=0, send 6 unmapped makes (1C, 1B, 23, 2B, 34, 33) -> FIFO holds 1C, 1B, 23, 2B; overflow pulses twice. Then evt_ready=1 -> events drain in order, 4 pops.
- Timeout and BAT: send E0, idle 100000 cycles, then send 14 -> event {14, 0, 0} (prefix dropped). With buttons=FF, send AA -> buttons=00, no event.
- Async reset: after E0 with 2 events queued, assert rst mid-cycle -> evt_valid and buttons are 0 immediately. After release, 75 yields {75, 0, 0}. With PS2_REPEAT_FILTER_EN, 14 14 14 yields a single event.
